// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 issue/hazard controller: register file
// geometry, the 2-bit opcode classes used by the decoder, and the FSM states.
package riscv_pkg;

    localparam int REG_AW = 5;
    localparam int NREG   = 32;

    // Opcode classes seen by the hazard logic
    localparam logic [1:0] ARITH      = 2'd0;
    localparam logic [1:0] LOGICAL    = 2'd1;
    localparam logic [1:0] LOAD_STORE = 2'd2;
    localparam logic [1:0] BRANCH     = 2'd3;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    // Register-usage flags for one decoded instruction
    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic wr_en;
    } dec_t;

    // Derive register usage from the opcode class. LOAD_STORE is treated as
    // a load here (reads the base register, writes rd); a store needs rs2 and
    // no write, which the decoder must override.
    function automatic dec_t decode_op(input logic [1:0] op);
        dec_t d;
        d = '0;
        case (op)
            ARITH, LOGICAL: d = '{use_rs1: 1'b1, use_rs2: 1'b1, wr_en: 1'b1};
            LOAD_STORE:     d = '{use_rs1: 1'b1, use_rs2: 1'b0, wr_en: 1'b1};
            default:        d = '{use_rs1: 1'b1, use_rs2: 1'b1, wr_en: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/riscv_hazard_ctrl_scoreboard.sv
// Register scoreboard: one busy bit per architectural register, set when a
// writing instruction issues and cleared when writeback retires it. Provides
// "effective busy" lookups that treat a register retiring this cycle as free.
module riscv_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREG   = riscv_pkg::NREG,
    parameter int REG_AW = riscv_pkg::REG_AW,
    parameter int NRD    = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr_en,
    input  logic [REG_AW-1:0]          clr_idx,
    input  logic                       set_en,
    input  logic [REG_AW-1:0]          set_idx,
    input  logic [NRD-1:0][REG_AW-1:0] rd_idx,
    output logic [NRD-1:0]             rd_busy,
    output logic [NREG-1:0]            busy_vec
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] eff_busy;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
            if (gi == 0) begin : g_x0
                // x0 is hardwired zero and can never be busy
                assign busy_d[gi]   = 1'b0;
                assign eff_busy[gi] = 1'b0;
            end else begin : g_xn
                logic clr_hit;
                logic set_hit;
                assign clr_hit      = clr_en && (clr_idx == REG_AW'(gi));
                assign set_hit      = set_en && (set_idx == REG_AW'(gi));
                // Retiring register is free this cycle (write-through RF)
                assign eff_busy[gi] = busy_q[gi] & ~clr_hit;
                // A new issue to the same register overrides the retire clear
                assign busy_d[gi]   = set_hit | eff_busy[gi];
            end
        end

        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            assign rd_busy[gi] = eff_busy[rd_idx[gi]];
        end
    endgenerate

    // Busy-vector state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Issue/hazard controller for the 5-stage RV32 pipeline. Stalls decode on
// RAW/WAW hazards against the scoreboard, flushes IF/ID and ID/EX for a fixed
// number of cycles after a taken branch, and counts stall/flush cycles.
module riscv_hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int NREG         = riscv_pkg::NREG,
    parameter int REG_AW       = riscv_pkg::REG_AW,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr_en,
    input  logic              ex_br_valid,
    input  logic              ex_br_taken,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    output logic              issue,
    output logic              stall,
    output logic              flush,
    output logic [NREG-1:0]   busy_vec,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Cycles spent in FLUSH after the cycle the branch resolves
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_e             state_q, state_d;
    logic [2:0]         fcnt_q, fcnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic [2:0][REG_AW-1:0] rd_idx;
    logic [2:0]             rd_busy;
    logic                   hazard;
    logic                   flush_raw;

    assign rd_idx = {id_rd, id_rs2, id_rs1};

    riscv_scoreboard #(
        .NREG   (NREG),
        .REG_AW (REG_AW),
        .NRD    (3)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .clr_en   (wb_valid),
        .clr_idx  (wb_rd),
        .set_en   (issue & id_wr_en),
        .set_idx  (id_rd),
        .rd_idx   (rd_idx),
        .rd_busy  (rd_busy),
        .busy_vec (busy_vec)
    );

    assign hazard = id_valid & ((id_use_rs1 & rd_busy[0]) |
                                (id_use_rs2 & rd_busy[1]) |
                                (id_wr_en   & rd_busy[2]));

    // Flush FSM next state; taken branches during FLUSH cannot be real
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        flush_raw = 1'b0;
        case (state_q)
            RUN: begin
                flush_raw = ex_br_valid & ex_br_taken;
                if (flush_raw && (FLUSH_CYCLES > 1)) begin
                    state_d = FLUSH;
                    fcnt_d  = FLUSH_INIT;
                end
            end
            FLUSH: begin
                flush_raw = 1'b1;
                if (fcnt_q <= 3'd1) begin
                    state_d = RUN;
                    fcnt_d  = 3'd0;
                end else begin
                    fcnt_d  = fcnt_q - 3'd1;
                end
            end
            default: begin
                state_d = RUN;
                fcnt_d  = 3'd0;
            end
        endcase
    end

    // Outputs are forced low while reset is held
    assign flush = flush_raw & ~reset;
    assign stall = hazard & ~flush & ~reset;
    assign issue = id_valid & ~hazard & ~flush & ~reset;

    // Saturating performance counter next values
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // FSM and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            fcnt_q      <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Directed testbench for riscv_hazard_ctrl (FLUSH_CYCLES=2, CNT_W=4).
module tb_riscv_hazard_ctrl;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_use_rs1, id_use_rs2, id_wr_en;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        ex_br_valid, ex_br_taken, wb_valid;
    logic        issue, stall, flush;
    logic [31:0] busy_vec;
    logic [3:0]  stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    riscv_hazard_ctrl #(
        .NREG(32), .REG_AW(5), .FLUSH_CYCLES(2), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_wr_en(id_wr_en),
        .ex_br_valid(ex_br_valid), .ex_br_taken(ex_br_taken),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .issue(issue), .stall(stall), .flush(flush),
        .busy_vec(busy_vec), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_wr_en = 0; ex_br_valid = 0; ex_br_taken = 0;
        wb_valid = 0; wb_rd = 0;
    endtask

    // Present one decode instruction; op class supplies the usage flags
    task automatic decode(input logic [1:0] op, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd);
        dec_t d;
        d = decode_op(op);
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_rs1 = d.use_rs1; id_use_rs2 = d.use_rs2; id_wr_en = d.wr_en;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        idle();
        next_cycle();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle();
        decode(ARITH, 5'd1, 5'd2, 5'd3);
        ex_br_valid = 1; ex_br_taken = 1;
        @(negedge clk);
        checks++; if (issue !== 1'b0) begin errors++; $display("FAIL reset_issue: got %b expected 0", issue); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", flush); end
        next_cycle();
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h expected 00000000", busy_vec); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
        checks++; if (flush_cnt !== 4'd0) begin errors++; $display("FAIL reset_flush_cnt: got %0d expected 0", flush_cnt); end
        $display("test_reset done");
    endtask

    task automatic test_raw();
        do_reset();
        decode(ARITH, 5'd1, 5'd2, 5'd3);
        @(negedge clk);
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL raw_first_issue: got %b expected 1", issue); end
        next_cycle();
        checks++; if (busy_vec !== 32'h8) begin errors++; $display("FAIL raw_busy_set: got %h expected 00000008", busy_vec); end
        decode(LOAD_STORE, 5'd3, 5'd0, 5'd6);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (stall !== 1'b1 || issue !== 1'b0) begin errors++; $display("FAIL raw_stall%0d: got stall=%b issue=%b expected stall=1 issue=0", i, stall, issue); end
            next_cycle();
        end
        wb_valid = 1; wb_rd = 5'd3;
        @(negedge clk);
        checks++; if (stall !== 1'b0 || issue !== 1'b1) begin errors++; $display("FAIL raw_release: got stall=%b issue=%b expected stall=0 issue=1", stall, issue); end
        next_cycle();
        idle();
        checks++; if (busy_vec !== 32'h40) begin errors++; $display("FAIL raw_busy_after: got %h expected 00000040", busy_vec); end
        checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL raw_stall_cnt: got %0d expected 3", stall_cnt); end
        $display("test_raw done");
    endtask

    task automatic test_x0_window();
        do_reset();
        decode(ARITH, 5'd1, 5'd2, 5'd0);
        @(negedge clk);
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL x0_issue: got %b expected 1", issue); end
        next_cycle();
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL x0_busy: got %h expected 00000000", busy_vec); end
        decode(ARITH, 5'd1, 5'd2, 5'd5);
        next_cycle();
        // Same register retires while being re-issued: set wins
        decode(ARITH, 5'd1, 5'd2, 5'd5);
        wb_valid = 1; wb_rd = 5'd5;
        @(negedge clk);
        checks++; if (issue !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL window_issue: got issue=%b stall=%b expected issue=1 stall=0", issue, stall); end
        next_cycle();
        checks++; if (busy_vec !== 32'h20) begin errors++; $display("FAIL window_busy: got %h expected 00000020", busy_vec); end
        idle();
        wb_valid = 1; wb_rd = 5'd0;
        next_cycle();
        wb_rd = 5'd7;
        next_cycle();
        idle();
        checks++; if (busy_vec !== 32'h20) begin errors++; $display("FAIL noop_clear: got %h expected 00000020", busy_vec); end
        $display("test_x0_window done");
    endtask

    task automatic test_waw();
        do_reset();
        decode(LOAD_STORE, 5'd0, 5'd0, 5'd4);
        next_cycle();
        id_valid = 1; id_use_rs1 = 0; id_use_rs2 = 0; id_rd = 5'd4; id_wr_en = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (stall !== 1'b1 || issue !== 1'b0) begin errors++; $display("FAIL waw_stall%0d: got stall=%b issue=%b expected stall=1 issue=0", i, stall, issue); end
            next_cycle();
        end
        id_valid = 0; id_use_rs1 = 1; id_rs1 = 5'd4;
        @(negedge clk);
        checks++; if (stall !== 1'b0 || issue !== 1'b0) begin errors++; $display("FAIL invalid_id: got stall=%b issue=%b expected 0 0", stall, issue); end
        next_cycle();
        id_valid = 1; id_use_rs1 = 0;
        wb_valid = 1; wb_rd = 5'd4;
        @(negedge clk);
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL waw_release: got %b expected 1", issue); end
        next_cycle();
        idle();
        checks++; if (busy_vec !== 32'h10) begin errors++; $display("FAIL waw_busy: got %h expected 00000010", busy_vec); end
        checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL waw_stall_cnt: got %0d expected 2", stall_cnt); end
        $display("test_waw done");
    endtask

    task automatic test_branch();
        do_reset();
        decode(LOAD_STORE, 5'd0, 5'd0, 5'd3);
        next_cycle();
        decode(LOAD_STORE, 5'd0, 5'd0, 5'd4);
        next_cycle();
        decode(ARITH, 5'd3, 5'd0, 5'd8);
        ex_br_valid = 1; ex_br_taken = 1;
        @(negedge clk);
        checks++; if (flush !== 1'b1 || stall !== 1'b0 || issue !== 1'b0) begin errors++; $display("FAIL br_cycle0: got flush=%b stall=%b issue=%b expected 1 0 0", flush, stall, issue); end
        next_cycle();
        // Second flush cycle; a spurious taken branch here must be ignored
        id_valid = 1; id_use_rs1 = 0; id_use_rs2 = 0; id_rd = 5'd9; id_wr_en = 1;
        @(negedge clk);
        checks++; if (flush !== 1'b1 || issue !== 1'b0) begin errors++; $display("FAIL br_cycle1: got flush=%b issue=%b expected 1 0", flush, issue); end
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL br_end: got %b expected 0", flush); end
        checks++; if (busy_vec !== 32'h18) begin errors++; $display("FAIL br_busy: got %h expected 00000018", busy_vec); end
        checks++; if (flush_cnt !== 4'd2 || stall_cnt !== 4'd0) begin errors++; $display("FAIL br_counts: got flush_cnt=%0d stall_cnt=%0d expected 2 0", flush_cnt, stall_cnt); end
        next_cycle();
        decode(LOAD_STORE, 5'd0, 5'd0, 5'd9);
        ex_br_valid = 1; ex_br_taken = 0;
        @(negedge clk);
        checks++; if (flush !== 1'b0 || issue !== 1'b1) begin errors++; $display("FAIL br_not_taken: got flush=%b issue=%b expected 0 1", flush, issue); end
        next_cycle();
        idle();
        checks++; if (busy_vec !== 32'h218) begin errors++; $display("FAIL br_nt_busy: got %h expected 00000218", busy_vec); end
        $display("test_branch done");
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        decode(LOAD_STORE, 5'd0, 5'd0, 5'd3);
        next_cycle();
        decode(LOAD_STORE, 5'd0, 5'd0, 5'd4);
        next_cycle();
        idle();
        ex_br_valid = 1; ex_br_taken = 1;
        next_cycle();
        idle();
        checks++; if (flush !== 1'b1 || busy_vec !== 32'h18) begin errors++; $display("FAIL mid_pre: got flush=%b busy=%h expected 1 00000018", flush, busy_vec); end
        reset = 1;
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mid_flush: got %b expected 0", flush); end
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL mid_busy: got %h expected 00000000", busy_vec); end
        checks++; if (flush_cnt !== 4'd0 || stall_cnt !== 4'd0) begin errors++; $display("FAIL mid_counts: got flush_cnt=%0d stall_cnt=%0d expected 0 0", flush_cnt, stall_cnt); end
        next_cycle();
        reset = 0;
        @(negedge clk);
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mid_after: got %b expected 0", flush); end
        next_cycle();
        $display("test_reset_mid_flush done");
    endtask

    task automatic test_saturation();
        do_reset();
        decode(LOAD_STORE, 5'd0, 5'd0, 5'd3);
        next_cycle();
        decode(LOAD_STORE, 5'd3, 5'd0, 5'd7);
        repeat (20) next_cycle();
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall: got %b expected 1", stall); end
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt: got %0d expected 15", stall_cnt); end
        next_cycle();
        idle();
        $display("test_saturation done");
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_raw();
        test_x0_window();
        test_waw();
        test_branch();
        test_reset_mid_flush();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_hazard_ctrl.md
Name: riscv_hazard_ctrl

Overview:
Issue and hazard controller for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
- Keeps a register scoreboard of in-flight destination registers.
- Stalls IF/ID on RAW/WAW hazards and flushes IF/ID and ID/EX after a taken branch resolves in EX.
- Exports saturating stall and flush performance counters.
- Sits beside the pipeline registers and gates their enables and valid bits.

Parameters:
NREG, 32, number of architectural registers; x0 is never busy
REG_AW, 5, register index width
FLUSH_CYCLES, 2, cycles flush is held after a taken branch (1..7)
CNT_W, 32, perf counter width

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-high reset
id_valid  in  1  decode stage holds a valid instruction
id_rs1  in  REG_AW  source register 1 of decode instruction
id_rs2  in  REG_AW  source register 2 of decode instruction
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd  in  REG_AW  destination register
id_wr_en  in  1  instruction writes rd (arithmetic, logical, load)
ex_br_valid  in  1  branch resolved in EX this cycle
ex_br_taken  in  1  resolved branch is taken (qualified by ex_br_valid)
wb_valid  in  1  writeback retires a register write this cycle
wb_rd  in  REG_AW  register retired
issue  out  1  decode instruction advances to EX this cycle
stall  out  1  hold PC and IF/ID; insert bubble into ID/EX
flush  out  1  invalidate IF/ID and ID/EX contents
busy_vec  out  NREG  registered scoreboard (debug)
stall_cnt  out  CNT_W  cycles with stall=1, saturating
flush_cnt  out  CNT_W  cycles with flush=1, saturating

Behaviour:
- Reset (async): busy_vec=0, state=RUN, flush counter=0, stall_cnt=0, flush_cnt=0. Combinational outputs at reset: issue=0, stall=0, flush=0.
- Reset mid-flush: returns to RUN immediately and discards the remaining flush count.
- Effective busy: eff_busy[r] = busy_vec[r] & ~(wb_valid & wb_rd==r). A register retiring this cycle does not cause a hazard (write-through register file). eff_busy[0] is always 0.
- hazard = id_valid & ((id_use_rs1 & eff_busy[id_rs1]) | (id_use_rs2 & eff_busy[id_rs2]) | (id_wr_en & eff_busy[id_rd])). The last term is the WAW hazard.
- FSM:
  - RUN: flush = ex_br_valid & ex_br_taken. On flush, go to FLUSH with count = FLUSH_CYCLES-1, or stay in RUN if FLUSH_CYCLES==1.
  - FLUSH: flush=1. Count decrements each cycle; at 0 return to RUN. A new taken branch while in FLUSH is ignored, since no valid branch can be in EX.
- Outputs, all combinational from state and inputs:
  - stall = hazard & ~flush
  - issue = id_valid & ~hazard & ~flush
- Scoreboard update at posedge:
  - Clear wb_rd if wb_valid.
  - Then set id_rd if issue & id_wr_en & id_rd!=0.
  - Set wins when both target the same register in one cycle.
  - A flushed instruction never sets a bit.
- Latency: hazard to stall takes 0 cycles. A bit set on issue at cycle N is visible in busy_vec at N+1. It is cleared at the posedge of the WB retire cycle.
- Counters increment by 1 per cycle of stall / flush and hold at all-ones.
- Boundaries:
  - wb_valid with wb_rd=0 has no effect.
  - Clearing a non-busy bit has no effect.
  - id_valid=0 gives issue=0 and stall=0.

Decomposition:
- Shared package riscv_pkg: REG_AW, NREG, opcode constants (ARITH=0, LOGICAL=1, LOAD_STORE=2, BRANCH=3), state enum {RUN, FLUSH}. The top-level decoder derives id_use_rs*/id_wr_en from these opcodes.
- One sub-module: riscv_scoreboard, holding the busy vector, the set/clear logic and the eff_busy lookup for three read ports.

Test Plan:
- RAW: issue add x3 (wr_en, rd=3). Next cycle, decode reads rs1=3 -> stall=1, issue=0, busy_vec[3]=1. Stall holds until wb_valid, wb_rd=3; that cycle stall=0, issue=1.
- x0 and the same-cycle window:
  - Write rd=0 -> busy_vec stays 0.
  - Issue rd=5 while wb_rd=5 retires -> busy_vec[5]=1 next cycle.
- WAW: rd=4 busy, decode writes rd=4 with no sources -> stall=1 until retire.
- Taken branch: ex_br_valid=ex_br_taken=1 while a hazard is present. Required: flush=1 for exactly 2 cycles, stall=0, issue=0, no scoreboard set, flush_cnt=2.
- Not-taken branch: ex_br_valid=1, ex_br_taken=0 -> flush=0, normal issue continues.
- Reset asserted in the 1st FLUSH cycle with busy_vec=0x18 -> busy_vec=0, flush=0, counters=0 immediately, without waiting for a clock edge.
- Counter saturation with CNT_W=4: hold a hazard for 20 cycles -> stall_cnt=15.
